// File: rtl/pedal_audio_pkg.sv
// -----------------------------------------------------------------------------
// pedal_audio_pkg
// Types and constants shared by the sample feeder and the PWM/sigma-delta DAC
// stage:
//   SAMPLE_W / SAMPLE_MID : sample width and the unsigned midscale (silence)
//   ST_*                  : bit positions inside the feeder's status byte
//   ctrl_t                : the three control bits the feeder reacts to
//   apply_gain()          : arithmetic right-shift of a sample about midscale
// -----------------------------------------------------------------------------
package pedal_audio_pkg;

    localparam int SAMPLE_W = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;

    localparam sample_t SAMPLE_MID = 8'h80;

    // Status byte layout: {3'b0, ovf, unf, full, empty, playing}
    localparam int ST_PLAYING = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_FULL    = 2;
    localparam int ST_UNF     = 3;
    localparam int ST_OVF     = 4;

    // ctrl[2:0]; packed MSB-first so that play lands on bit 0
    typedef struct packed {
        logic clear;  // clear sticky ovf/unf (level)
        logic flush;  // empty the FIFO (level)
        logic play;   // run the sample-rate divider
    } ctrl_t;

    // Attenuate a sample by 2^shift around midscale. The sample is re-centred
    // to a signed 9-bit value so that the shift is symmetric for both halves
    // of the waveform (0x00 >>> 1 gives 0x40, 0xFF >>> 2 gives 0x9F).
    function automatic sample_t apply_gain(input sample_t s, input logic [1:0] shift);
        logic signed [SAMPLE_W:0] centred;
        logic signed [SAMPLE_W:0] restored;
        centred  = $signed({1'b0, s}) - $signed({1'b0, SAMPLE_MID});
        centred  = centred >>> shift;
        restored = centred + $signed({1'b0, SAMPLE_MID});
        return restored[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Show-ahead synchronous FIFO. The oldest entry is always visible on head; a
// pushed word becomes visible the cycle after push. count/full/empty are
// registered together so they always agree with each other.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request and data (ignored while full unless popping)
//   pop        : consume head (ignored while empty)
//   flush      : level; pointers and count return to 0 on the next edge
//   head       : current oldest entry
//   count      : occupancy 0..DEPTH
//   full/empty : registered occupancy flags
// -----------------------------------------------------------------------------
module sample_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_next;
    logic             push_ok;
    logic             pop_ok;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // legal when it coincides with a pop.
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && (!full || pop_ok) && !flush;

    assign head = mem[rd_ptr];

    always_comb begin
        // NOTE: default first so every path assigns count_next; no latch.
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_next = count - CNT_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy is tracked by the
    // pointers and count, so stale data is never observable.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples
    // the values from before the edge.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;  // wraps modulo DEPTH (power of 2)
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
            full  <= (count_next == CNT_DEPTH);
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/pwm_sample_feeder.sv
// -----------------------------------------------------------------------------
// pwm_sample_feeder
// Sample-rate buffer in front of the DAC stage. The CPU writes 8-bit unsigned
// samples into a FIFO; a fixed divider pops one sample every DIV clocks and
// presents it on sample_out with a one-cycle sample_stb pulse.
//
// Build option: define SAMPLE_GAIN_EN to add gain_shift[1:0], which attenuates
// popped samples by 2^gain_shift about midscale (sampled at the tick).
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   wr_data     : sample from CPU bus (unsigned, midscale 0x80)
//   wr_en       : write strobe, one sample per cycle
//   ctrl        : bit0 play, bit1 flush (level), bit2 clear flags (level)
//   gain_shift  : (SAMPLE_GAIN_EN only) attenuation shift 0..3
//   sample_out  : sample to the DAC stage
//   sample_stb  : one-cycle pulse when sample_out updates
//   status      : {3'b0, ovf, unf, full, empty, playing}
//   fifo_count  : FIFO occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module pwm_sample_feeder
    import pedal_audio_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DIV   = 6250
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SAMPLE_W-1:0]      wr_data,
    input  logic                     wr_en,
    input  logic [7:0]               ctrl,
`ifdef SAMPLE_GAIN_EN
    input  logic [1:0]               gain_shift,
`endif
    output logic [SAMPLE_W-1:0]      sample_out,
    output logic                     sample_stb,
    output logic [7:0]               status,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    ctrl_t         ctrl_s;
    logic          unused_ctrl;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          pop;
    logic          push;
    logic          underrun;
    logic          overflow;
    logic          fifo_full;
    logic          fifo_empty;
    sample_t       head;
    sample_t       popped;
    logic          playing;
    logic          unf;
    logic          ovf;

    assign ctrl_s      = ctrl_t'(ctrl[2:0]);
    assign unused_ctrl = ^ctrl[7:3];

    // ---------------- sample-rate divider ----------------
    // Held at 0 while stopped so the first tick lands DIV cycles after play.
    assign tick = ctrl_s.play && (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset || !ctrl_s.play || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    // ---------------- FIFO handshake ----------------
    // A flush suppresses both sides; a tick during flush is an empty pop.
    // empty is registered, so a write landing in the tick cycle of an empty
    // FIFO cannot be popped yet and the tick is an underrun.
    assign pop      = tick && !fifo_empty && !ctrl_s.flush;
    assign underrun = tick && (fifo_empty || ctrl_s.flush);
    assign push     = wr_en && !ctrl_s.flush && (!fifo_full || pop);
    assign overflow = wr_en && !ctrl_s.flush && fifo_full && !pop;

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (ctrl_s.flush),
        .din   (wr_data),
        .head  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef SAMPLE_GAIN_EN
    assign popped = apply_gain(head, gain_shift);
`else
    assign popped = head;
`endif

    // ---------------- output register and flags ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out <= SAMPLE_MID;
            sample_stb <= 1'b0;
            playing    <= 1'b0;
            unf        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            playing    <= ctrl_s.play;
            sample_stb <= tick;
            if (tick) begin
                sample_out <= pop ? popped : SAMPLE_MID;
            end else if (!ctrl_s.play) begin
                sample_out <= SAMPLE_MID;  // idle at silence while stopped
            end
            // A set in the same cycle as a clear wins.
            unf <= underrun || (unf && !ctrl_s.clear);
            ovf <= overflow || (ovf && !ctrl_s.clear);
        end
    end

    always_comb begin
        status              = '0;
        status[ST_PLAYING]  = playing;
        status[ST_EMPTY]    = fifo_empty;
        status[ST_FULL]     = fifo_full;
        status[ST_UNF]      = unf;
        status[ST_OVF]      = ovf;
    end

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// -----------------------------------------------------------------------------
// tb_pwm_sample_feeder
// Directed bench for pwm_sample_feeder with DEPTH=16, DIV=4. Inputs change 1 ns
// after the rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_pwm_sample_feeder;
    import pedal_audio_pkg::*;

    localparam int DEPTH = 16;
    localparam int DIV   = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic [7:0]    ctrl;
`ifdef SAMPLE_GAIN_EN
    logic [1:0]    gain_shift;
`endif
    logic [7:0]    sample_out;
    logic          sample_stb;
    logic [7:0]    status;
    logic [CW-1:0] fifo_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pwm_sample_feeder #(
        .DEPTH (DEPTH),
        .DIV   (DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .ctrl       (ctrl),
`ifdef SAMPLE_GAIN_EN
        .gain_shift (gain_shift),
`endif
        .sample_out (sample_out),
        .sample_stb (sample_stb),
        .status     (status),
        .fifo_count (fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    // DIV-1 quiet cycles, then a strobe carrying exp
    task automatic expect_sample(input string tag, input logic [7:0] exp);
        for (int i = 0; i < DIV - 1; i++) begin
            step();
            check({tag, " quiet"}, 32'(sample_stb), 32'd0);
        end
        step();
        check({tag, " stb"},  32'(sample_stb), 32'd1);
        check({tag, " data"}, 32'(sample_out), 32'(exp));
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        ctrl    = 8'h00;
`ifdef SAMPLE_GAIN_EN
        gain_shift = 2'd0;
`endif

        // 1: reset state
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset stb", 32'(sample_stb), 32'd0);
        end
        check("reset sample_out", 32'(sample_out), 32'h80);
        check("reset status",     32'(status),     32'h02);
        check("reset count",      32'(fifo_count), 32'd0);
        reset = 1'b0;

        // 2: three samples, then an underrun
        write(8'h10);
        write(8'h20);
        write(8'h30);
        check("t2 count", 32'(fifo_count), 32'd3);
        ctrl = 8'h01;
        expect_sample("t2 s0", 8'h10);
        check("t2 playing", 32'(status[ST_PLAYING]), 32'd1);
        expect_sample("t2 s1", 8'h20);
        expect_sample("t2 s2", 8'h30);
        expect_sample("t2 unf", 8'h80);
        check("t2 unf flag", 32'(status[ST_UNF]), 32'd1);
        ctrl = 8'h00;
        step();
        check("disable sample_out", 32'(sample_out), 32'h80);
        check("disable stb",        32'(sample_stb), 32'd0);
        check("disable status",     32'(status),     32'h0A);
        ctrl = 8'h04;
        step();
        check("t2 clear status", 32'(status), 32'h02);
        ctrl = 8'h00;

        // 3: DEPTH+1 writes with play off; last one dropped
        for (int i = 0; i <= DEPTH; i++) begin
            write(8'(8'h40 + i));
        end
        check("t3 count",  32'(fifo_count), 32'(DEPTH));
        check("t3 status", 32'(status),     32'h14);
        ctrl = 8'h04;
        step();
        check("t3 clear ovf", 32'(status), 32'h04);

        // 4: write coincident with the tick while full
        ctrl = 8'h01;
        for (int i = 0; i < DIV - 1; i++) begin
            step();
            check("t4 quiet", 32'(sample_stb), 32'd0);
        end
        wr_en   = 1'b1;
        wr_data = 8'h99;
        step();
        wr_en   = 1'b0;
        check("t4 stb",    32'(sample_stb), 32'd1);
        check("t4 data",   32'(sample_out), 32'h40);
        check("t4 count",  32'(fifo_count), 32'(DEPTH));
        check("t4 status", 32'(status),     32'h05);
        for (int i = 1; i < DEPTH; i++) begin
            expect_sample("t4 drain", 8'(8'h40 + i));
        end
        expect_sample("t4 late write", 8'h99);   // 0x50 was dropped in t3
        expect_sample("t4 unf", 8'h80);
        ctrl = 8'h00;
        step();
        ctrl = 8'h04;
        step();
        check("t4 end status", 32'(status), 32'h02);

        // 5: flush, tick during flush, clear vs set
        ctrl = 8'h00;
        for (int i = 0; i < 5; i++) begin
            write(8'(8'h70 + i));
        end
        check("t5 queued", 32'(fifo_count), 32'd5);
        ctrl = 8'h03;
        step();
        check("t5 flush count", 32'(fifo_count),       32'd0);
        check("t5 flush empty", 32'(status[ST_EMPTY]), 32'd1);
        write(8'h11);
        check("t5 write ignored", 32'(fifo_count), 32'd0);
        step();
        check("t5 quiet", 32'(sample_stb), 32'd0);
        step();
        check("t5 flush tick stb",  32'(sample_stb),     32'd1);
        check("t5 flush tick data", 32'(sample_out),     32'h80);
        check("t5 flush tick unf",  32'(status[ST_UNF]), 32'd1);
        ctrl = 8'h04;
        step();
        check("t5 clear unf", 32'(status[ST_UNF]), 32'd0);
        ctrl = 8'h05;
        expect_sample("t5 set+clear", 8'h80);
        check("t5 set wins", 32'(status[ST_UNF]), 32'd1);
        ctrl = 8'h04;
        step();
        check("t5 cleared again", 32'(status[ST_UNF]), 32'd0);
        ctrl = 8'h00;
        step();

        // reset mid-operation
        write(8'h55);
        write(8'h66);
        ctrl = 8'h01;
        step();
        step();
        reset = 1'b1;
        step();
        check("midreset count",  32'(fifo_count), 32'd0);
        check("midreset sample", 32'(sample_out), 32'h80);
        check("midreset status", 32'(status),     32'h02);
        reset = 1'b0;
        ctrl  = 8'h00;
        step();

`ifdef SAMPLE_GAIN_EN
        // 6: gain
        gain_shift = 2'd2;
        write(8'hFF);
        write(8'h00);
        write(8'h37);
        ctrl = 8'h01;
        expect_sample("t6 ff>>>2", 8'h9F);
        expect_sample("t6 00>>>2", 8'h60);
        gain_shift = 2'd0;
        expect_sample("t6 shift0", 8'h37);
        ctrl = 8'h00;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
